perf_event_counter: RTL
=======================

Name: perf_event_counter

Overview:
Synthesizable pipeline performance monitor for the pipelined CPU. It provides NUM_EVT parametrised event channels (stall, flush, retire, etc.) and one free-running cycle counter. Counting is gated by a run/stop state machine with an optional cycle limit, and all counters can be read through a one-cycle request/valid readout port. It sits beside the CPU core and replaces ad-hoc bench-side stall/flush tallies with on-chip counters.

Parameters:
NUM_EVT, 4, number of event channels (1..16)
CNT_W, 32, width of each counter, including the cycle counter (8..64)
MAX_CYCLES, 30, cycle limit for auto-stop; 0 = unlimited
SEL_W, $clog2(NUM_EVT+1), width of the readout select

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  run enable; level-sensitive
clr_i  in  1  synchronous clear of all counters, ovf and state
evt_i  in  NUM_EVT  per-channel event strobe, one count per cycle when high
rd_req_i  in  1  readout request
rd_sel_i  in  SEL_W  0..NUM_EVT-1 = event channel; NUM_EVT = cycle counter
rd_data_o  out  CNT_W  readout data
rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid while it is high
running_o  out  1  state == RUN and start_i high (counting this cycle)
done_o  out  1  high in state DONE
ovf_o  out  NUM_EVT+1  sticky saturation flags; bit NUM_EVT = cycle counter

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, all counters=0, ovf_o=0, rd_data_o=0, rd_valid_o=0, done_o=0. Reset has priority over everything else.
- Priority below reset: clr_i > state transitions/counting. clr_i zeroes counters and ovf, drops any request pending that cycle (rd_valid_o=0 next cycle), and sends state to IDLE.
- States:
  - IDLE: no counting. start_i=1 -> RUN at the next edge. The cycle in which start_i first rises is not counted.
  - RUN: each cycle with start_i=1, the cycle counter increments by 1 and event counter k increments by 1 if evt_i[k]=1. start_i=0 in RUN pauses counting and holds values; state stays RUN.
  - RUN -> DONE: MAX_CYCLES != 0 and a counting cycle takes the cycle counter to MAX_CYCLES. Events in that final cycle are counted, so exactly MAX_CYCLES cycles are observed.
  - DONE: counters frozen, start_i ignored. Only clr_i or rst_i leaves DONE (to IDLE).
- Arithmetic: unsigned. A counter at all-ones stays saturated (no wrap), and its ovf bit sets and stays set until clr/reset. An increment attempted while the counter is all-ones also sets ovf.
- Readout:
  - rd_req_i=1 at edge t -> rd_valid_o=1 and rd_data_o = selected counter value held before edge t's increment, both visible after edge t for exactly one cycle.
  - Back-to-back requests are allowed; each returns one result.
  - rd_sel_i > NUM_EVT returns 0 with rd_valid_o=1.
  - Readout works in every state and does not disturb counting.
  - rd_data_o holds its last value when rd_valid_o=0.
- running_o and done_o are combinational from state and start_i.

Test Plan:
- Reset/idle: rst_i=1 for 2 cycles, then evt_i=4'hF with start_i=0 for 10 cycles -> all reads return 0, done_o=0, ovf_o=0.
- Basic count: MAX_CYCLES=30, start_i=1, evt_i[0] high every 3rd cycle, evt_i[1] constantly high -> done_o rises after 30 counting cycles; reads give cycle=30, ch1=30, ch0=10; further events do not change any value.
- Pause: start_i low for 5 cycles mid-run -> cycle counter and event counters hold; done_o occurs 5 cycles later than in an unpaused run.
- Saturation: CNT_W=8, MAX_CYCLES=0, evt_i[2]=1 for 300 cycles -> ch2 reads 255, ovf_o[2]=1, ovf_o[NUM_EVT]=1; clr_i -> all 0, ovf 0, state IDLE.
- Readout timing: rd_req_i with rd_sel_i=1 issued on the same edge that ch1 increments from 7 to 8 -> next cycle rd_valid_o=1, rd_data_o=7. rd_sel_i=NUM_EVT+1 -> 0.
- Clear/reset mid-run: clr_i in the same cycle as start_i=1 and evt_i high -> counters 0, state IDLE, nothing counted. rst_i asserted in DONE -> returns to IDLE with all outputs 0.

Source files
------------

// File: rtl/perf_event_counter.sv
// Pipeline performance monitor: NUM_EVT saturating event counters plus a
// cycle counter, gated by a run/stop FSM, with a one-cycle readout port.
module perf_event_counter #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30,
    parameter int SEL_W      = $clog2(NUM_EVT+1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clr_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               rd_req_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_valid_o,
    output logic               running_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL1  = '1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q [NUM_EVT+1];
    logic [NUM_EVT:0] ovf_q;
    logic [NUM_EVT:0] inc;
    logic             counting;
    logic             hit_lim;
    logic [CNT_W-1:0] rd_word;

    always_comb begin
        counting = (state_q == RUN) && start_i;
        inc      = {1'b1, evt_i} & {(NUM_EVT+1){counting}};
        // A saturated cycle counter never reaches the limit by wrapping
        hit_lim  = (MAX_CYCLES != 0) && counting &&
                   (cnt_q[NUM_EVT] != ALL1) &&
                   (cnt_q[NUM_EVT] + ONE == LIMIT);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (hit_lim) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (rd_sel_i == SEL_W'(k)) rd_word = cnt_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ovf_q      <= '0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            for (int k = 0; k <= NUM_EVT; k++) cnt_q[k] <= '0;
        end else if (clr_i) begin
            state_q    <= IDLE;
            ovf_q      <= '0;
            rd_valid_o <= 1'b0;
            for (int k = 0; k <= NUM_EVT; k++) cnt_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_o <= rd_req_i;
            if (rd_req_i) rd_data_o <= rd_word;
            for (int k = 0; k <= NUM_EVT; k++) begin
                if (inc[k]) begin
                    if (cnt_q[k] != ALL1) cnt_q[k] <= cnt_q[k] + ONE;
                    // Flag on reaching all-ones as well as on a blocked increment
                    if (cnt_q[k] >= ALL1 - ONE) ovf_q[k] <= 1'b1;
                end
            end
        end
    end

    assign running_o = counting;
    assign done_o    = (state_q == DONE);
    assign ovf_o     = ovf_q;

endmodule
